// File: rtl/counter_pkg.sv
// Shared widths, build defaults and the seconds-advance rule for the elapsed-seconds counter.
package counter_pkg;

   localparam int SECONDS_W           = 10;
   localparam int DEFAULT_CLK_FREQ_HZ = 2_500_000;
   localparam int DEFAULT_MAX_SECONDS = 999;

   // Value seconds takes on a tick: +1, and at the top either wrap to 0 or hold.
   function automatic logic [SECONDS_W-1:0] next_seconds(
      input logic [SECONDS_W-1:0] cur,
      input logic [SECONDS_W-1:0] max_val,
      input logic                 saturate
   );
      logic [SECONDS_W-1:0] nxt;
      nxt = cur + SECONDS_W'(1);
      if (cur >= max_val) begin
         nxt = saturate ? max_val : '0;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/counter_tick_prescaler.sv
// Free-running 0..DIV-1 prescaler; tick is a registered one-cycle pulse on each wrap.
// wrap flags the last count so the parent can update state on the same edge as tick.
module tick_prescaler #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic tick,
   output logic wrap
);

   localparam int W = (DIV < 2) ? 1 : $clog2(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   if (DIV < 2) begin : g_bad_div
      $error("tick_prescaler: DIV must be at least 2");
   end

   logic [W-1:0] count;

   assign wrap = (count == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         tick  <= 1'b0;
      end else begin
         tick  <= wrap;
         count <= wrap ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/counter.sv
// Elapsed-seconds counter: prescaled one-second tick plus a seconds register.
// Build option COUNTER_SATURATE_EN: seconds holds at MAX_SECONDS instead of wrapping to 0.
module counter
   import counter_pkg::*;
#(
   parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
   parameter int MAX_SECONDS = DEFAULT_MAX_SECONDS
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [SECONDS_W-1:0] seconds,
   output logic                 tick
);

   if (MAX_SECONDS > 1023 || MAX_SECONDS < 0) begin : g_bad_max
      $error("counter: MAX_SECONDS must be in 0..1023");
   end

`ifdef COUNTER_SATURATE_EN
   localparam logic SATURATE = 1'b1;
`else
   localparam logic SATURATE = 1'b0;
`endif

   localparam logic [SECONDS_W-1:0] MAX_VAL = SECONDS_W'(MAX_SECONDS);

   logic wrap;

   tick_prescaler #(
      .DIV (CLK_FREQ_HZ)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .wrap (wrap)
   );

   // Advance on the wrap edge so the new value appears in the same cycle as tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seconds <= '0;
      end else if (wrap) begin
         seconds <= next_seconds(seconds, MAX_VAL, SATURATE);
      end
   end

endmodule

// File: tb/tb_counter.sv
// Bench for counter at CLK_FREQ_HZ=4, MAX_SECONDS=2 against an edge-counting model.
module tb_counter;

   localparam int DIV     = 4;
   localparam int MAXS    = 2;
   localparam int HALF_NS = 200;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] seconds;
   logic       tick;

   int total = 0;
   int bad   = 0;
   bit started = 1'b0;
   int edges = 0;

   counter #(
      .CLK_FREQ_HZ (DIV),
      .MAX_SECONDS (MAXS)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .seconds (seconds),
      .tick    (tick)
   );

   always #HALF_NS clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: count edges seen with rst low since the last reset assertion.
   always @(posedge rst) edges = 0;
   always @(posedge clk) if (!rst) edges++;

   function automatic int model_seconds(input int ticks);
`ifdef COUNTER_SATURATE_EN
      return (ticks > MAXS) ? MAXS : ticks;
`else
      return ticks % (MAXS + 1);
`endif
   endfunction

   always @(negedge clk) begin
      if (started) begin
         int exp_tick;
         int exp_sec;
         if (rst) begin
            exp_tick = 0;
            exp_sec  = 0;
         end else begin
            exp_tick = (edges > 0 && edges % DIV == 0) ? 1 : 0;
            exp_sec  = model_seconds(edges / DIV);
         end
         check("model_tick", 32'(tick), 32'(exp_tick));
         check("model_seconds", 32'(seconds), 32'(exp_sec));
      end
   end

   int tick_lit [16] = '{0,0,0,1, 0,0,0,1, 0,0,0,1, 0,0,0,1};
`ifdef COUNTER_SATURATE_EN
   int sec_lit  [16] = '{0,0,0,1, 1,1,1,2, 2,2,2,2, 2,2,2,2};
`else
   int sec_lit  [16] = '{0,0,0,1, 1,1,1,2, 2,2,2,0, 0,0,0,1};
`endif

   initial begin
      #10 rst = 1'b1;
      started = 1'b1;
      #240;
      check("reset_tick", 32'(tick), 32'd0);
      check("reset_seconds", 32'(seconds), 32'd0);
      #50 rst = 1'b0;

      // First 16 edges after release: tick on 4,8,12,16; wrap/saturate sequence.
      for (int k = 0; k < 16; k++) begin
         @(posedge clk);
         #1;
         check("lit_tick", 32'(tick), 32'(tick_lit[k]));
         check("lit_seconds", 32'(seconds), 32'(sec_lit[k]));
      end

      // Asynchronous reset mid-count discards the partial second.
      repeat (2) @(posedge clk);
      #150 rst = 1'b1;
      #1;
      check("async_rst_tick", 32'(tick), 32'd0);
      check("async_rst_seconds", 32'(seconds), 32'd0);
      #100 rst = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         check("restart_tick", 32'(tick), (k == 4) ? 32'd1 : 32'd0);
         check("restart_seconds", 32'(seconds), (k == 4) ? 32'd1 : 32'd0);
      end

      // Reset held across ten edges keeps everything at zero.
      @(posedge clk);
      #100 rst = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check("held_rst_tick", 32'(tick), 32'd0);
         check("held_rst_seconds", 32'(seconds), 32'd0);
      end
      #100 rst = 1'b0;

      // Random runs, sub-period reset pulses and long resets.
      for (int it = 0; it < 60; it++) begin
         int sel;
         sel = int'($urandom_range(0, 9));
         if (sel < 6) begin
            repeat (int'($urandom_range(1, 14))) @(posedge clk);
         end else if (sel < 9) begin
            @(posedge clk);
            #($urandom_range(20, 150)) rst = 1'b1;
            #($urandom_range(10, 40)) rst = 1'b0;
         end else begin
            @(posedge clk);
            #60 rst = 1'b1;
            repeat (int'($urandom_range(1, 5))) @(posedge clk);
            #120 rst = 1'b0;
         end
      end
      repeat (20) @(posedge clk);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
